data_mem_unit: RTL and testbench

Data-memory responder for the core's memory stage. Consumes the `memRead`/`memWrite` controls and the LR.W/SC.W atomic decode produced by the control decoder, and runs a request/acknowledge transaction on the data bus. Handles byte/half/word lane alignment, load sign extension and the LR/SC reservation. It also stalls the pipeline until each access retires.

---
 rtl/data_mem_unit_pkg.sv | 33 +++
 rtl/load_store_align.sv | 45 ++++
 rtl/data_mem_unit.sv | 148 ++++++++++++++
 tb/tb_data_mem_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared constants and types for the data-memory responder:
// access-size codes, AMO decode values, FSM states and byte strobes.
package data_mem_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] OP_AMO = 7'b0101111;
  localparam logic [4:0] F5_LR  = 5'b00010;
  localparam logic [4:0] F5_SC  = 5'b00011;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Unknown size codes fall back to a full word.
  function automatic size_t size_of(input logic [2:0] func3);
    case (func3)
      F3_LB, F3_LBU: size_of = SZ_B;
      F3_LH, F3_LHU: size_of = SZ_H;
      F3_LW:         size_of = SZ_W;
      default:       size_of = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store strobes/replication, alignment check,
// and load lane extraction with sign or zero extension.
module load_store_align
  import data_mem_unit_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_value
);

  size_t       size;
  logic [31:0] shifted;
  logic        is_signed;

  assign size      = size_of(func3);
  assign shifted   = rdata >> {addr_lo, 3'b000};
  assign is_signed = ~func3[2];

  always_comb begin
    strb       = STRB_W;
    wdata      = store_data;
    misaligned = 1'b0;
    load_value = rdata;
    case (size)
      SZ_B: begin
        strb       = 4'(STRB_B << addr_lo);
        wdata      = {4{store_data[7:0]}};
        load_value = {{24{shifted[7] & is_signed}}, shifted[7:0]};
      end
      SZ_H: begin
        strb       = 4'(STRB_H << addr_lo);
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
        load_value = {{16{shifted[15] & is_signed}}, shifted[15:0]};
      end
      default: misaligned = |addr_lo;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Memory-stage responder: runs one bus transaction per load/store,
// tracks the LR/SC reservation and stalls the pipeline until retirement.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              isLr,
  input  logic              isSc,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storeData,
  output logic [DATA_W-1:0] loadData,
  output logic              stall,
  output logic              misaligned,
  output logic              busReq,
  output logic              busWe,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWdata,
  output logic [3:0]        busStrb,
  input  logic              busAck,
  input  logic [DATA_W-1:0] busRdata
);

  localparam int unsigned WORD_W = ADDR_W - 2;

  state_t              state, state_n;
  logic                res_valid, res_valid_n;
  logic [WORD_W-1:0]   res_addr, res_addr_n;
  logic [DATA_W-1:0]   load_data_n, bus_wdata_n;
  logic [ADDR_W-1:0]   bus_addr_n;
  logic [3:0]          bus_strb_n;
  logic                bus_req_n, bus_we_n, misaligned_n;

  logic                request, fault, sc_fail, res_hit_bus;
  logic                align_mis;
  logic [3:0]          align_strb;
  logic [DATA_W-1:0]   align_wdata, align_load;

  load_store_align u_align (
    .addr_lo    (addr[1:0]),
    .func3      (func3),
    .store_data (storeData),
    .rdata      (busRdata),
    .strb       (align_strb),
    .wdata      (align_wdata),
    .misaligned (align_mis),
    .load_value (align_load)
  );

  assign request     = memRead | memWrite;
  assign fault       = align_mis | ((isLr | isSc) & (addr[1:0] != 2'b00));
  assign sc_fail     = isSc & ~(res_valid & (res_addr == addr[ADDR_W-1:2]));
  assign res_hit_bus = res_valid & (res_addr == busAddr[ADDR_W-1:2]);
  assign stall       = ~reset & request & (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      res_valid  <= 1'b0;
      res_addr   <= '0;
      loadData   <= '0;
      misaligned <= 1'b0;
      busReq     <= 1'b0;
      busWe      <= 1'b0;
      busAddr    <= '0;
      busWdata   <= '0;
      busStrb    <= STRB_NONE;
    end else begin
      state      <= state_n;
      res_valid  <= res_valid_n;
      res_addr   <= res_addr_n;
      loadData   <= load_data_n;
      misaligned <= misaligned_n;
      busReq     <= bus_req_n;
      busWe      <= bus_we_n;
      busAddr    <= bus_addr_n;
      busWdata   <= bus_wdata_n;
      busStrb    <= bus_strb_n;
    end
  end

  always_comb begin
    state_n      = state;
    res_valid_n  = res_valid;
    res_addr_n   = res_addr;
    load_data_n  = loadData;
    misaligned_n = misaligned;
    bus_req_n    = busReq;
    bus_we_n     = busWe;
    bus_addr_n   = busAddr;
    bus_wdata_n  = busWdata;
    bus_strb_n   = busStrb;
    case (state)
      ST_IDLE: begin
        if (request) begin
          if (fault) begin
            state_n      = ST_DONE;
            misaligned_n = 1'b1;
            load_data_n  = '0;
          end else if (sc_fail) begin
            state_n     = ST_DONE;
            load_data_n = DATA_W'(1);
            res_valid_n = 1'b0;
          end else begin
            state_n     = ST_REQ;
            bus_req_n   = 1'b1;
            bus_we_n    = memWrite;
            bus_addr_n  = {addr[ADDR_W-1:2], 2'b00};
            bus_wdata_n = align_wdata;
            bus_strb_n  = memWrite ? (isSc ? STRB_W : align_strb) : STRB_NONE;
          end
        end
      end
      ST_REQ: begin
        if (busAck) begin
          state_n    = ST_DONE;
          bus_req_n  = 1'b0;
          bus_we_n   = 1'b0;
          bus_strb_n = STRB_NONE;
          if (!busWe) begin
            load_data_n = align_load;
            if (isLr) begin
              res_valid_n = 1'b1;
              res_addr_n  = busAddr[ADDR_W-1:2];
            end
          end else if (isSc) begin
            load_data_n = '0;
            res_valid_n = 1'b0;
          end else if (res_hit_bus) begin
            res_valid_n = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_n      = ST_IDLE;
        misaligned_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: lane handling, wait states,
// LR/SC reservation, alignment faults and reset during a transaction.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        reset, memRead, memWrite, isLr, isSc, busAck;
  logic [2:0]  func3;
  logic [31:0] addr, storeData, busRdata, loadData, busAddr, busWdata;
  logic        stall, misaligned, busReq, busWe;
  logic [3:0]  busStrb;

  int checks = 0;
  int errors = 0;

  logic        saw_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_strb;
  int          stalls;

  data_mem_unit dut (
    .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
    .isLr(isLr), .isSc(isSc), .func3(func3), .addr(addr),
    .storeData(storeData), .loadData(loadData), .stall(stall),
    .misaligned(misaligned), .busReq(busReq), .busWe(busWe),
    .busAddr(busAddr), .busWdata(busWdata), .busStrb(busStrb),
    .busAck(busAck), .busRdata(busRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then hold the access until stall drops; ack after wait_n REQ cycles.
  task automatic acc(input logic rd, input logic wr, input logic lr, input logic sc,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rdat, input int wait_n);
    int waited;
    memRead = 1'b0; memWrite = 1'b0; isLr = 1'b0; isSc = 1'b0; busAck = 1'b0;
    step();
    memRead = rd; memWrite = wr; isLr = lr; isSc = sc;
    func3 = f3; addr = a; storeData = sd; busRdata = rdat;
    saw_req = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_strb = '0;
    stalls = 0; waited = 0;
    #1;
    for (int c = 0; c < 40 && stall === 1'b1; c++) begin
      stalls++;
      if (busReq) begin
        if (!saw_req) begin
          cap_we = busWe; cap_addr = busAddr; cap_wdata = busWdata; cap_strb = busStrb;
        end
        saw_req = 1'b1;
        if (waited == wait_n) busAck = 1'b1;
        else waited++;
      end
      @(posedge clk);
      #1;
      busAck = 1'b0;
    end
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL access_timeout: stall still %b after 40 cycles", stall);
    end
  endtask

  initial begin
    reset = 1'b1; memRead = 1'b1; memWrite = 1'b0; isLr = 1'b0; isSc = 1'b0;
    busAck = 1'b0; func3 = 3'b010; addr = '0; storeData = '0; busRdata = '0;
    step();
    step();
    chk("reset_stall", stall, 0);
    chk("reset_busReq", busReq, 0);
    chk("reset_busWe", busWe, 0);
    chk("reset_busAddr", busAddr, 0);
    chk("reset_busStrb", busStrb, 0);
    chk("reset_busWdata", busWdata, 0);
    chk("reset_loadData", loadData, 0);
    chk("reset_misaligned", misaligned, 0);
    reset = 1'b0; memRead = 1'b0;

    acc(1, 0, 0, 0, 3'b000, 32'h1003, 0, 32'h80FF_FF7F, 0);
    chk("lb_busAddr", cap_addr, 32'h1000);
    chk("lb_busStrb", cap_strb, 4'b0000);
    chk("lb_busWe", cap_we, 0);
    chk("lb_stalls", stalls, 2);
    chk("lb_loadData", loadData, 32'hFFFF_FF80);

    acc(1, 0, 0, 0, 3'b100, 32'h1003, 0, 32'h80FF_FF7F, 0);
    chk("lbu_loadData", loadData, 32'h0000_0080);

    acc(1, 0, 0, 0, 3'b001, 32'h1002, 0, 32'h80FF_FF7F, 0);
    chk("lh_loadData", loadData, 32'hFFFF_80FF);

    acc(1, 0, 0, 0, 3'b101, 32'h1000, 0, 32'h80FF_FF7F, 0);
    chk("lhu_loadData", loadData, 32'h0000_FF7F);

    acc(0, 1, 0, 0, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 3);
    chk("sh_busStrb", cap_strb, 4'b1100);
    chk("sh_busWdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_busWe", cap_we, 1);
    chk("sh_busAddr", cap_addr, 32'h2000);
    chk("sh_stalls", stalls, 5);

    acc(0, 1, 0, 0, 3'b000, 32'h2001, 32'h1234_5678, 0, 0);
    chk("sb_busStrb", cap_strb, 4'b0010);
    chk("sb_busWdata", cap_wdata, 32'h7878_7878);

    acc(1, 0, 1, 0, 3'b010, 32'h3000, 0, 32'hDEAD_BEEF, 0);
    chk("lr_loadData", loadData, 32'hDEAD_BEEF);
    acc(0, 1, 0, 1, 3'b010, 32'h3000, 32'h0000_0011, 0, 0);
    chk("sc_ok_busReq", saw_req, 1);
    chk("sc_ok_busStrb", cap_strb, 4'b1111);
    chk("sc_ok_busWe", cap_we, 1);
    chk("sc_ok_loadData", loadData, 0);
    acc(0, 1, 0, 1, 3'b010, 32'h3000, 32'h0000_0022, 0, 0);
    chk("sc_again_loadData", loadData, 1);
    chk("sc_again_busReq", saw_req, 0);
    chk("sc_again_stalls", stalls, 1);

    acc(1, 0, 1, 0, 3'b010, 32'h4000, 0, 32'h0000_0001, 0);
    acc(0, 1, 0, 0, 3'b010, 32'h4000, 32'h5555_5555, 0, 1);
    acc(0, 1, 0, 1, 3'b010, 32'h4000, 32'h0000_0033, 0, 0);
    chk("kill_sc_loadData", loadData, 1);
    chk("kill_sc_busReq", saw_req, 0);
    acc(1, 0, 1, 0, 3'b010, 32'h4000, 0, 32'h0000_0001, 0);
    acc(0, 1, 0, 0, 3'b010, 32'h4004, 32'h5555_5555, 0, 1);
    acc(0, 1, 0, 1, 3'b010, 32'h4000, 32'h0000_0044, 0, 0);
    chk("keep_sc_loadData", loadData, 0);
    chk("keep_sc_busReq", saw_req, 1);

    acc(1, 0, 0, 0, 3'b010, 32'h5002, 0, 32'h1111_1111, 0);
    chk("mis_flag", misaligned, 1);
    chk("mis_busReq", saw_req, 0);
    chk("mis_stalls", stalls, 1);
    memRead = 1'b0;
    step();
    chk("mis_clears", misaligned, 0);

    acc(1, 0, 1, 0, 3'b010, 32'h6000, 0, 32'hCAFE_F00D, 0);
    chk("lr2_loadData", loadData, 32'hCAFE_F00D);
    memRead = 1'b0; isLr = 1'b0;
    step();
    memRead = 1'b1; func3 = 3'b010; addr = 32'h6000; busRdata = 32'hAAAA_5555;
    #1;
    chk("rst_mid_stall_idle", stall, 1);
    step();
    chk("rst_mid_busReq", busReq, 1);
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_stall_forced", stall, 0);
    step();
    reset = 1'b0; memRead = 1'b0;
    chk("rst_after_busReq", busReq, 0);
    chk("rst_after_loadData", loadData, 0);
    busAck = 1'b1;
    step();
    busAck = 1'b0;
    chk("late_ack_loadData", loadData, 0);
    chk("late_ack_busReq", busReq, 0);
    acc(0, 1, 0, 1, 3'b010, 32'h6000, 32'h0000_0055, 0, 0);
    chk("rst_sc_loadData", loadData, 1);
    chk("rst_sc_busReq", saw_req, 0);

    memWrite = 1'b0; isSc = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
